// File: rtl/fifo_pkg.sv
// Shared types and constants for the single-clock FIFO family.
// Holds the read-mode enum, default geometry/thresholds and pointer sizing.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int DEFAULT_DSIZE         = 32;
    localparam int DEFAULT_ASIZE         = 2;
    localparam int DEFAULT_AEMPTY_THRESH = 1;

    // One extra wrap bit lets full and empty be told apart with equal low bits.
    function automatic int ptr_width(input int asize);
        return asize + 1;
    endfunction

    function automatic int default_afull_thresh(input int asize);
        return (1 << asize) - 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for sync_fifo: one synchronous write port and one
// asynchronous read port.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = DEFAULT_DSIZE,
    parameter int ASIZE = DEFAULT_ASIZE
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ASIZE-1:0] wr_addr,
    input  logic [DSIZE-1:0] wr_data,
    input  logic [ASIZE-1:0] rd_addr,
    output logic [DSIZE-1:0] rd_data
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];

    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are valid, so resetting the array would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with optional first-word-fall-through, almost-full/empty
// thresholds, occupancy count, synchronous flush and sticky error flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE         = DEFAULT_DSIZE,
    parameter int ASIZE         = DEFAULT_ASIZE,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = default_afull_thresh(ASIZE),
    parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             clear_errors,
    input  logic             write_enable,
    input  logic [DSIZE-1:0] write_data,
    output logic             write_full,
    output logic             write_almost_full,
    input  logic             read_enable,
    output logic [DSIZE-1:0] read_data,
    output logic             read_empty,
    output logic             read_almost_empty,
    output logic [ASIZE:0]   fill_count,
    output logic             overflow,
    output logic             underflow
);

    localparam int            PW         = ptr_width(ASIZE);
    localparam fifo_mode_e    MODE       = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [PW-1:0] AFULL_CNT  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_CNT = PW'(AEMPTY_THRESH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [PW-1:0]    count;
    logic             full;
    logic             empty;
    logic             write_accept;
    logic             read_accept;
    logic [DSIZE-1:0] mem_rd_data;

    // Status is decoded only from registered pointers, never from inputs.
    always_comb begin
        count = wptr_q - rptr_q;
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
    end

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        write_accept = write_enable && !full && !flush;
        read_accept  = read_enable && !empty && !flush;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        overflow_d   = overflow_q && !clear_errors;
        underflow_d  = underflow_q && !clear_errors;

        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (write_accept) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (read_accept) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            // A rejected request in the same edge as clear_errors still sets.
            if (write_enable && full) begin
                overflow_d = 1'b1;
            end
            if (read_enable && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .wr_en   (write_accept),
        .wr_addr (wptr_q[ASIZE-1:0]),
        .wr_data (write_data),
        .rd_addr (rptr_q[ASIZE-1:0]),
        .rd_data (mem_rd_data)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head word is visible as soon as it is stored; zero while empty.
            assign read_data = empty ? '0 : mem_rd_data;
        end else begin : g_std
            logic [DSIZE-1:0] read_data_q, read_data_d;

            always_comb begin
                read_data_d = read_data_q;
                if (read_accept) begin
                    read_data_d = mem_rd_data;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    read_data_q <= '0;
                end else begin
                    read_data_q <= read_data_d;
                end
            end

            assign read_data = read_data_q;
        end
    endgenerate

    assign write_full        = full;
    assign read_empty        = empty;
    assign fill_count        = count;
    assign write_almost_full = (count >= AFULL_CNT);
    assign read_almost_empty = (count <= AEMPTY_CNT);
    assign overflow          = overflow_q;
    assign underflow         = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-mode and an FWFT instance share stimulus and
// are compared every cycle against a queue-based model of the FIFO.
module tb_sync_fifo;

    localparam int DSIZE = 32;
    localparam int ASIZE = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic             clk          = 1'b0;
    logic             reset_n      = 1'b1;
    logic             flush        = 1'b0;
    logic             clear_errors = 1'b0;
    logic             write_enable = 1'b0;
    logic             read_enable  = 1'b0;
    logic [DSIZE-1:0] write_data   = '0;

    logic             s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
    logic [DSIZE-1:0] s_rd;
    logic [ASIZE:0]   s_fill;
    logic             f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
    logic [DSIZE-1:0] f_rd;
    logic [ASIZE:0]   f_fill;

    always #5 clk = ~clk;

    sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(0)) dut_s (
        .clk (clk), .reset_n (reset_n), .flush (flush), .clear_errors (clear_errors),
        .write_enable (write_enable), .write_data (write_data),
        .write_full (s_full), .write_almost_full (s_afull),
        .read_enable (read_enable), .read_data (s_rd),
        .read_empty (s_empty), .read_almost_empty (s_aempty),
        .fill_count (s_fill), .overflow (s_ovf), .underflow (s_unf)
    );

    sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(1)) dut_f (
        .clk (clk), .reset_n (reset_n), .flush (flush), .clear_errors (clear_errors),
        .write_enable (write_enable), .write_data (write_data),
        .write_full (f_full), .write_almost_full (f_afull),
        .read_enable (read_enable), .read_data (f_rd),
        .read_empty (f_empty), .read_almost_empty (f_aempty),
        .fill_count (f_fill), .overflow (f_ovf), .underflow (f_unf)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the last standard-mode read.
    logic [31:0] q[$];
    logic [31:0] m_std_rd = '0;
    bit          m_ovf    = 1'b0;
    bit          m_unf    = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_std_rd = '0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            bit was_full, was_empty;
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (clear_errors) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (write_enable && was_full)  m_ovf = 1'b1;
                if (read_enable && was_empty)  m_unf = 1'b1;
                if (read_enable && !was_empty) m_std_rd = q.pop_front();
                if (write_enable && !was_full) q.push_back(write_data);
            end
        end
    end

    always @(negedge clk) begin
        int          n;
        logic [31:0] head;
        n    = q.size();
        head = (n == 0) ? 32'd0 : q[0];
        check("s_fill_count",  32'(s_fill),   32'(n));
        check("s_read_empty",  32'(s_empty),  32'(n == 0));
        check("s_write_full",  32'(s_full),   32'(n == DEPTH));
        check("s_almost_full", 32'(s_afull),  32'(n >= AF));
        check("s_almost_empty",32'(s_aempty), 32'(n <= AE));
        check("s_overflow",    32'(s_ovf),    32'(m_ovf));
        check("s_underflow",   32'(s_unf),    32'(m_unf));
        check("s_read_data",   s_rd,          m_std_rd);
        check("f_fill_count",  32'(f_fill),   32'(n));
        check("f_read_empty",  32'(f_empty),  32'(n == 0));
        check("f_write_full",  32'(f_full),   32'(n == DEPTH));
        check("f_overflow",    32'(f_ovf),    32'(m_ovf));
        check("f_underflow",   32'(f_unf),    32'(m_unf));
        check("f_read_data",   f_rd,          head);
    end

    task automatic cyc(input logic we, input logic [31:0] wd, input logic re,
                       input logic fl = 1'b0, input logic ce = 1'b0);
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        flush        = fl;
        clear_errors = ce;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        flush        = 1'b0;
        clear_errors = 1'b0;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_empty",    32'(s_empty),  32'd1);
        check("rst_aempty",   32'(s_aempty), 32'd1);
        check("rst_fwft_rd",  f_rd,          32'd0);

        // Fill to full, then drain in order.
        cyc(1'b1, 32'hA0, 1'b0);
        cyc(1'b1, 32'hA1, 1'b0);
        check("afull_at_2", 32'(s_afull), 32'd0);
        cyc(1'b1, 32'hA2, 1'b0);
        check("afull_at_3", 32'(s_afull), 32'd1);
        cyc(1'b1, 32'hA3, 1'b0);
        check("full_at_4",  32'(s_full),  32'd1);
        check("fill_at_4",  32'(s_fill),  32'd4);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            check("std_drain", s_rd, 32'hA0 + 32'(i));
        end
        check("drained_empty", 32'(s_empty), 32'd1);

        // Write+read while full: read wins, write dropped, overflow sticks.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hB0 + 32'(i), 1'b0);
        cyc(1'b1, 32'hFF, 1'b1);
        check("ovf_set",      32'(s_ovf),  32'd1);
        check("ovf_fill",     32'(s_fill), 32'd3);
        check("ovf_rd",       s_rd,        32'hB0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("ovf_cleared",  32'(s_ovf),  32'd0);
        for (int i = 1; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            check("ovf_drain", s_rd, 32'hB0 + 32'(i));
        end

        // Read while empty, then read+write while empty.
        cyc(1'b0, 32'h0, 1'b1);
        check("unf_set",  32'(s_unf), 32'd1);
        check("unf_hold", s_rd,       32'hB3);
        cyc(1'b1, 32'h55, 1'b1);
        check("unf_wr_fill", 32'(s_fill), 32'd1);
        check("unf_wr_fwft", f_rd,        32'h55);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // FWFT head visibility.
        check("fwft_empty_zero", f_rd, 32'h0);
        cyc(1'b1, 32'h11, 1'b0);
        check("fwft_not_empty", 32'(f_empty), 32'd0);
        check("fwft_head",      f_rd,         32'h11);
        cyc(1'b1, 32'h22, 1'b1);
        check("fwft_next",      f_rd,         32'h22);
        check("fwft_fill",      32'(f_fill),  32'd1);
        check("std_got_11",     s_rd,         32'h11);
        cyc(1'b0, 32'h0, 1'b1);

        // Flush beats a simultaneous write and leaves read_data alone.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hC0 + 32'(i), 1'b0);
        cyc(1'b1, 32'h99, 1'b0, 1'b1);
        check("flush_fill",  32'(s_fill), 32'd0);
        check("flush_empty", 32'(s_empty), 32'd1);
        check("flush_ovf",   32'(s_ovf),  32'd0);
        check("flush_rd",    s_rd,        32'h22);

        // Pointer wrap with steady write+read.
        cyc(1'b1, 32'hD0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 32'hD0 + 32'(i), 1'b1);
            check("wrap_order", s_rd, 32'hD0 + 32'(i - 1));
        end
        cyc(1'b0, 32'h0, 1'b1);
        check("wrap_last", s_rd, 32'hDA);

        // Random traffic: write-heavy then read-heavy, rare flush/clear.
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = (i < 300) ? 70 : 30;
            cyc(1'(($urandom_range(0, 99)) < wp), $urandom,
                1'(($urandom_range(0, 99)) < (100 - wp)),
                1'($urandom_range(0, 47) == 0),
                1'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-cycle with data and an error flag present.
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hE0 + 32'(i), 1'b0);
        cyc(1'b1, 32'hEE, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        check("pre_rst_ovf",  32'(s_ovf),  32'd1);
        check("pre_rst_fill", 32'(s_fill), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        check("arst_fill",   32'(s_fill),   32'd0);
        check("arst_empty",  32'(s_empty),  32'd1);
        check("arst_full",   32'(s_full),   32'd0);
        check("arst_afull",  32'(s_afull),  32'd0);
        check("arst_aempty", 32'(s_aempty), 32'd1);
        check("arst_ovf",    32'(s_ovf),    32'd0);
        check("arst_std_rd", s_rd,          32'd0);
        check("arst_fwft_rd",f_rd,          32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 32'hF0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        check("post_rst_rd", s_rd, 32'hF0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
